// File: rtl/debouncer_array_if.sv
// rtl/debouncer_array_if.sv - signal bundle between a debouncer_array and its user
// Purpose: carries the sample strobe, raw inputs and the debounced results.
// Ports (signals):
//   tick       sample strobe, driven by master
//   inp        raw asynchronous inputs, driven by master
//   out        debounced level per channel, driven by slave
//   rise       one-cycle 0->1 event per channel, driven by slave
//   fall       one-cycle 1->0 event per channel, driven by slave
//   any_event  OR of all rise/fall pulses, driven by slave
interface debouncer_array_if #(
    parameter int CHANNELS = 4
);
    logic                tick;
    logic [CHANNELS-1:0] inp;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_event;

    modport master (
        output tick,
        output inp,
        input  out,
        input  rise,
        input  fall,
        input  any_event
    );

    modport slave (
        input  tick,
        input  inp,
        output out,
        output rise,
        output fall,
        output any_event
    );
endinterface

// File: rtl/debouncer_array.sv
// rtl/debouncer_array.sv - multi-channel synchronising debouncer with edge pulses
// Purpose: per channel, synchronise a raw input, accept a new level only after
//   DEBOUNCE_CYCLES consecutive tick-sampled agreeing samples, and pulse rise/fall
//   on the cycle the debounced level changes.
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  debouncer_array_if slave: tick, inp in; out, rise, fall, any_event out
module debouncer_array #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    debouncer_array_if.slave    bus
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_LOW      = 2'd0;
    localparam logic [1:0] ST_CNT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH     = 2'd2;
    localparam logic [1:0] ST_CNT_LOW  = 2'd3;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    logic [1:0]          state_q [CHANNELS];
    logic [1:0]          state_d [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] rise_d;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] fall_d;
    logic                any_q;

    // Synchroniser runs every clock, independent of tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.inp;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-channel FSM; count holds the number of agreeing samples seen so far
    // in the current window, so the window closes when it reaches DEBOUNCE_CYCLES-1
    // and the current sample agrees once more.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = '0;
        fall_d  = '0;
        if (bus.tick) begin
            for (int i = 0; i < CHANNELS; i++) begin
                case (state_q[i])
                    ST_LOW: begin
                        if (s[i]) begin
                            state_d[i] = ST_CNT_HIGH;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                    ST_CNT_HIGH: begin
                        if (!s[i]) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                            out_d[i]   = 1'b1;
                            rise_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!s[i]) begin
                            state_d[i] = ST_CNT_LOW;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                    ST_CNT_LOW: begin
                        if (s[i]) begin
                            state_d[i] = ST_HIGH;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = ST_LOW;
                            cnt_d[i]   = '0;
                            out_d[i]   = 1'b0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Pulses are recomputed every cycle, so they drop on tick=0 cycles too.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_LOW;
                cnt_q[i]   <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= |(rise_d | fall_d);
        end
    end

    assign bus.out       = out_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.any_event = any_q;

endmodule

// File: tb/tb_debouncer_array.sv
// tb/tb_debouncer_array.sv - self-checking bench for debouncer_array
module tb_debouncer_array;

    localparam int CH = 2;
    localparam int DB = 4;
    localparam int SS = 2;

    logic clk;
    logic rst;

    debouncer_array_if #(.CHANNELS(CH)) bus ();

    debouncer_array #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [1:0] inp;
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       any;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the input seen by the debouncer is the raw input delayed
    // by SS edges; a level is accepted once DB consecutive ticked samples disagree
    // with the current output.
    logic [CH-1:0] hist [SS];
    logic [CH-1:0] m_out;
    logic [CH-1:0] m_rise;
    logic [CH-1:0] m_fall;
    logic          m_any;
    int            run [CH];

    task automatic model_step(input logic r, input logic t, input logic [CH-1:0] i_v);
        logic [CH-1:0] sv;
        if (r) begin
            for (int k = 0; k < SS; k++) hist[k] = '0;
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_any  = 1'b0;
            for (int c = 0; c < CH; c++) run[c] = 0;
            return;
        end
        sv     = hist[SS-1];
        m_rise = '0;
        m_fall = '0;
        if (t) begin
            for (int c = 0; c < CH; c++) begin
                if (sv[c] != m_out[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DB) begin
                        m_out[c] = sv[c];
                        if (sv[c]) m_rise[c] = 1'b1;
                        else       m_fall[c] = 1'b1;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        m_any = |(m_rise | m_fall);
        for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = i_v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, sample on the falling edge.
    task automatic drive(input logic r, input logic t, input logic [CH-1:0] i_v);
        rst      = r;
        bus.tick = t;
        bus.inp  = i_v;
        @(posedge clk);
        model_step(r, t, i_v);
        @(negedge clk);
    endtask

    // Counts edges until out[ch] goes high, bounded.
    task automatic wait_out(input int ch, input logic [CH-1:0] i_v, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            drive(1'b0, 1'b1, i_v);
            edges++;
            if (bus.out[ch]) seen = 1'b1;
        end
        if (!seen) edges = 99;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [10:0]   rel_pat;
        int            edges;
        logic          seen;
        logic [CH-1:0] rin;

        rst      = 1'b1;
        bus.tick = 1'b0;
        bus.inp  = '0;
        for (int k = 0; k < SS; k++) hist[k] = '0;
        m_out = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        for (int c = 0; c < CH; c++) run[c] = 0;
        @(negedge clk);

        // Table: reset, clean press on ch0, then release with bounce 1,0,1,0,0,...
        vecs.push_back('{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0});
        for (int r = 1; r <= 8; r++) begin
            vecs.push_back('{1'b0, 1'b1, 2'b01,
                             (r >= 6) ? 2'b01 : 2'b00,
                             (r == 6) ? 2'b01 : 2'b00,
                             2'b00,
                             (r == 6)});
        end
        rel_pat = 11'b000_0000_0101;
        for (int j = 0; j <= 10; j++) begin
            vecs.push_back('{1'b0, 1'b1, {1'b0, rel_pat[j]},
                             (j >= 8) ? 2'b00 : 2'b01,
                             2'b00,
                             (j == 8) ? 2'b01 : 2'b00,
                             (j == 8)});
        end
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].tick, vecs[k].inp);
            chk($sformatf("vec%0d out", k),  bus.out,       vecs[k].out);
            chk($sformatf("vec%0d rise", k), bus.rise,      vecs[k].rise);
            chk($sformatf("vec%0d fall", k), bus.fall,      vecs[k].fall);
            chk($sformatf("vec%0d any", k),  bus.any_event, vecs[k].any);
        end

        // Glitch rejection: 3 high samples then low, then a real press.
        drive(1'b1, 1'b1, 2'b00);
        seen = 1'b0;
        repeat (3) begin
            drive(1'b0, 1'b1, 2'b01);
            seen = seen | bus.out[0] | bus.rise[0];
        end
        repeat (10) begin
            drive(1'b0, 1'b1, 2'b00);
            seen = seen | bus.out[0] | bus.rise[0];
        end
        chk("glitch_no_change", seen, 0);
        wait_out(0, 2'b01, edges);
        chk("glitch_then_press_latency", edges, SS + DB);

        // Tick gating: tick on every 3rd cycle, ch1 held high.
        drive(1'b1, 1'b1, 2'b00);
        for (int c = 0; c < 15; c++) begin
            drive(1'b0, (c % 3) == 2, 2'b10);
            if (c == 10) chk("tick_out_before", bus.out[1], 0);
            if (c == 11) begin
                chk("tick_out_after", bus.out[1], 1);
                chk("tick_rise", bus.rise, 2'b10);
            end
            if (c == 12) chk("tick_rise_cleared_on_idle", bus.rise, 2'b00);
        end

        // Two-cycle glitch that the synchroniser presents only between ticks.
        drive(1'b1, 1'b1, 2'b00);
        seen = 1'b0;
        for (int c = 0; c < 21; c++) begin
            drive(1'b0, (c % 3) == 2, (c == 1 || c == 2) ? 2'b10 : 2'b00);
            seen = seen | bus.out[1] | bus.rise[1];
        end
        chk("tick_glitch_ignored", seen, 0);

        // Simultaneous press on both channels.
        drive(1'b1, 1'b1, 2'b00);
        for (int e = 1; e <= 7; e++) begin
            drive(1'b0, 1'b1, 2'b11);
            if (e == 5) chk("simul_rise_early", bus.rise, 2'b00);
            if (e == 6) begin
                chk("simul_rise", bus.rise, 2'b11);
                chk("simul_any", bus.any_event, 1);
            end
            if (e == 7) begin
                chk("simul_any_one_cycle", bus.any_event, 0);
                chk("simul_rise_one_cycle", bus.rise, 2'b00);
            end
        end

        // Reset while ch0 is mid-count.
        drive(1'b1, 1'b1, 2'b00);
        repeat (4) drive(1'b0, 1'b1, 2'b01);
        drive(1'b1, 1'b1, 2'b01);
        chk("midrst_out", bus.out, 2'b00);
        chk("midrst_rise", bus.rise, 2'b00);
        chk("midrst_any", bus.any_event, 0);
        wait_out(0, 2'b01, edges);
        chk("midrst_latency", edges, SS + DB);

        // Randomised run against the model.
        drive(1'b1, 1'b1, 2'b00);
        rin = '0;
        for (int n = 0; n < 800; n++) begin
            logic r_r;
            logic r_t;
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) rin[c] = ~rin[c];
            end
            r_t = ($urandom_range(0, 3) != 0);
            r_r = ($urandom_range(0, 299) == 0);
            drive(r_r, r_t, rin);
            chk($sformatf("rand%0d out", n),  bus.out,       m_out);
            chk($sformatf("rand%0d rise", n), bus.rise,      m_rise);
            chk($sformatf("rand%0d fall", n), bus.fall,      m_fall);
            chk($sformatf("rand%0d any", n),  bus.any_event, m_any);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
